// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and burst helpers for the ROM responder.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } trans_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } burst_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  // Beats in a fixed-length burst; 0 marks the undefined-length INCR.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      BURST_SINGLE:             return 5'd1;
      BURST_INCR:               return 5'd0;
      BURST_WRAP4, BURST_INCR4: return 5'd4;
      BURST_WRAP8, BURST_INCR8: return 5'd8;
      default:                  return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Tracks the burst in progress and predicts the only address a legal SEQ beat may carry.
module ahb_burst_addr_gen
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        advance,
  input  logic        clear,
  input  logic [31:0] addr,
  input  logic [2:0]  burst,
  output logic [31:0] next_addr,
  output logic        active
);

  logic [2:0]  burst_q;
  logic [31:0] addr_q;
  logic [4:0]  left_q;
  logic        active_q;
  logic [31:0] wrap_mask;

  // Bits inside the mask roll over within the aligned wrap block; all-ones means plain increment.
  always_comb begin
    wrap_mask = '1;
    case (burst_q)
      BURST_WRAP4:  wrap_mask = 32'h0000_000F;
      BURST_WRAP8:  wrap_mask = 32'h0000_001F;
      BURST_WRAP16: wrap_mask = 32'h0000_003F;
      default:      wrap_mask = '1;
    endcase
  end

  assign next_addr = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
  assign active    = active_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      burst_q  <= '0;
      addr_q   <= '0;
      left_q   <= '0;
    end else if (clear) begin
      active_q <= 1'b0;
    end else if (start) begin
      burst_q  <= burst;
      addr_q   <= addr;
      left_q   <= burst_beats(burst) - 5'd1;
      active_q <= (burst != BURST_SINGLE);
    end else if (advance) begin
      addr_q <= addr;
      if (burst_beats(burst_q) != 5'd0) begin
        left_q <= left_q - 5'd1;
        if (left_q == 5'd1) active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_rom_responder.sv
// AHB-Lite read-only subordinate over a backdoor-loaded word memory with programmable
// wait states; illegal transfers receive the two-cycle ERROR response.
module ahb_rom_responder
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          NSEQ_WAIT   = 2,
  parameter int          SEQ_WAIT    = 0,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsel,
  input  logic [31:0]      haddr,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic [2:0]       hsize,
  input  logic [2:0]       hburst,
  output logic [31:0]      hrdata,
  output logic             hready,
  output logic             hresp,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [31:0]      ld_data
);

  localparam logic [32:0] WINDOW = 33'(DEPTH_WORDS) << 2;

  logic [31:0]      mem [DEPTH_WORDS];
  state_t           state, state_d;
  logic [7:0]       cnt, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      hrdata_q;

  logic        accept, is_seq, in_range, illegal;
  logic [31:0] offset, next_addr;
  logic        burst_active;
  logic [7:0]  wait_sel;

  assign hready = (state != ST_WAIT) && (state != ST_ERR1);
  assign hresp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  // DATA reads the array directly so a same-cycle backdoor write lands after the read.
  assign hrdata = (state == ST_DATA) ? mem[idx_q] : hrdata_q;

  assign accept   = hsel && htrans[1] && hready;
  assign is_seq   = (htrans == TRANS_SEQ);
  assign offset   = haddr - BASE_ADDR;
  assign in_range = (haddr >= BASE_ADDR) && ({1'b0, offset} < WINDOW);
  assign illegal  = hwrite || (hsize != HSIZE_WORD) || (haddr[1:0] != 2'b00) || !in_range
                  || (is_seq && (!burst_active || (haddr != next_addr)));
  assign wait_sel = is_seq ? 8'(SEQ_WAIT) : 8'(NSEQ_WAIT);

  ahb_burst_addr_gen u_burst (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && !is_seq && !illegal),
    .advance   (accept && is_seq && !illegal),
    .clear     (accept && illegal),
    .addr      (haddr),
    .burst     (hburst),
    .next_addr (next_addr),
    .active    (burst_active)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_WAIT: begin
        cnt_d = cnt - 8'd1;
        if (cnt == 8'd1) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      ST_DATA: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // accept is only possible while hready is high, i.e. in IDLE, DATA or ERR2
    if (accept) begin
      if (illegal) begin
        state_d = ST_ERR1;
      end else if (wait_sel == 8'd0) begin
        state_d = ST_DATA;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = wait_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      hrdata_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept && !illegal) idx_q <= offset[IDX_W+1:2];
      if (state == ST_DATA) hrdata_q <= mem[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en && !rst) mem[ld_idx] <= ld_data;
  end

endmodule

// File: tb/tb_ahb_rom_responder.sv
// Randomized and directed bench for ahb_rom_responder against a transaction-level memory/burst model.
module tb_ahb_rom_responder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 1024;
  localparam int          IDX_W = 10;
  localparam int          NSEQ  = 2;
  localparam int          SEQW  = 0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hsel = 1'b0;
  logic [31:0]      haddr = '0;
  logic [1:0]       htrans = 2'd0;
  logic             hwrite = 1'b0;
  logic [2:0]       hsize = 3'b010;
  logic [2:0]       hburst = 3'd0;
  logic [31:0]      hrdata;
  logic             hready, hresp;
  logic             ld_en = 1'b0;
  logic [IDX_W-1:0] ld_idx = '0;
  logic [31:0]      ld_data = '0;

  always #5 clk = ~clk;

  ahb_rom_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .NSEQ_WAIT(NSEQ), .SEQ_WAIT(SEQW)
  ) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  typedef struct { logic sel; logic [1:0] trans; logic [31:0] addr; logic [2:0] burst; logic write; logic [2:0] size; } item_t;
  typedef struct { int waits; logic resp0; logic resp; logic [31:0] data; } obs_t;
  typedef struct { bit err; int waits; logic [31:0] data; } exp_t;

  item_t items[$];
  obs_t  obs[$];
  exp_t  exps[$];
  bit    timed_out;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  bit          m_active = 0;
  int          m_left = 0;
  logic [2:0]  m_burst = 3'd0;
  logic [31:0] m_next = '0;
  logic [31:0] m_last = '0;

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'd0: return 1;
      3'd1: return -1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int wrap_len(input logic [2:0] b);
    case (b)
      3'd2: return 4;
      3'd4: return 8;
      3'd6: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] next_of(input logic [31:0] a, input logic [2:0] b);
    longint blk, la;
    if (wrap_len(b) == 0) return a + 32'd4;
    blk = 4 * wrap_len(b);
    la  = longint'(a);
    return 32'(la - la % blk + (la % blk + 4) % blk);
  endfunction

  task automatic push(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic [2:0] b, input logic w, input logic [2:0] sz);
    item_t it;
    it.sel = sel; it.trans = tr; it.addr = a; it.burst = b; it.write = w; it.size = sz;
    items.push_back(it);
  endtask

  task automatic rd(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b);
    push(1'b1, tr, a, b, 1'b0, 3'b010);
  endtask

  // Walks the scripted transfers in order and derives each data-phase response.
  task automatic predict();
    exps.delete();
    foreach (items[k]) begin
      exp_t   e;
      item_t  it;
      bit     bad;
      longint off;
      it = items[k];
      e.err = 0; e.waits = 0; e.data = m_last;
      if (it.sel && (it.trans == 2'd2 || it.trans == 2'd3)) begin
        off = longint'(it.addr) - longint'(BASE);
        bad = it.write || it.size != 3'b010 || it.addr[1:0] != 2'b00 || off < 0 || off >= 4 * DEPTH;
        if (it.trans == 2'd3 && (!m_active || it.addr != m_next)) bad = 1;
        if (bad) begin
          e.err = 1; e.waits = 1; m_active = 0;
        end else begin
          if (it.trans == 2'd2) begin
            m_burst = it.burst;
            m_left  = beats_of(it.burst);
          end
          if (m_left > 0) m_left--;
          m_active = (m_left != 0);
          m_next   = next_of(it.addr, m_burst);
          e.waits  = (it.trans == 2'd2) ? NSEQ : SEQW;
          e.data   = mem_m[off / 4];
          m_last   = e.data;
        end
      end
      exps.push_back(e);
    end
  endtask

  task automatic drive_item(input int i);
    if (i < items.size()) begin
      hsel = items[i].sel; htrans = items[i].trans; haddr = items[i].addr;
      hburst = items[i].burst; hwrite = items[i].write; hsize = items[i].size;
    end else begin
      hsel = 1'b0; htrans = 2'd0; haddr = '0; hburst = 3'd0; hwrite = 1'b0; hsize = 3'b010;
    end
  endtask

  // Pipelined manager: holds each address phase until hready, records every data phase.
  task automatic run_items();
    int   i, cyc, dcyc, limit;
    bit   dp_v;
    obs_t cur;
    i = 0; cyc = 0; dcyc = 0; dp_v = 0; timed_out = 0;
    cur = '{0, 1'b0, 1'b0, 32'h0};
    limit = 20 * items.size() + 50;
    obs.delete();
    @(posedge clk); #1;
    drive_item(0);
    while (i < items.size() || dp_v) begin
      @(negedge clk);
      cyc++;
      if (cyc > limit) begin timed_out = 1; break; end
      if (dp_v) begin
        if (dcyc == 0) cur.resp0 = hresp;
        dcyc++;
        if (hready !== 1'b1) cur.waits++;
        else begin
          cur.resp = hresp; cur.data = hrdata;
          obs.push_back(cur);
          dp_v = 0;
        end
      end
      if (hready === 1'b1 && i < items.size()) begin
        dp_v = 1; dcyc = 0; i++;
        cur = '{0, 1'b0, 1'b0, 32'h0};
      end
      @(posedge clk); #1;
      drive_item(i);
    end
    drive_item(items.size());
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_idx = IDX_W'(idx); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mem_m[idx] = d;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hready !== 1'b1) begin failures++; $display("FAIL reset_hready: got %b want 1", hready); end
    checks++; if (hresp !== 1'b0) begin failures++; $display("FAIL reset_hresp: got %b want 0", hresp); end
    checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata: got %h want 0", hrdata); end
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) load(k, $urandom);
  endtask

  task automatic test_single();
    load(4, 32'hDEAD_BEEF);
    items.delete();
    rd(2'd2, 32'h10, 3'd0);
    rd(2'd0, 32'h0, 3'd0);
    predict(); run_items();
    if (timed_out || obs.size() != exps.size()) begin
      checks++; failures++; $display("FAIL single_count: got %0d transfers want %0d", obs.size(), exps.size());
    end else foreach (exps[k]) begin
      checks++;
      if (obs[k].waits !== exps[k].waits || obs[k].resp0 !== exps[k].err || obs[k].resp !== exps[k].err
          || (!exps[k].err && obs[k].data !== exps[k].data)) begin
        failures++;
        $display("FAIL single beat %0d: got waits=%0d resp=%b/%b data=%h want waits=%0d resp=%b data=%h",
                 k, obs[k].waits, obs[k].resp0, obs[k].resp, obs[k].data, exps[k].waits, exps[k].err, exps[k].data);
      end
    end
  endtask

  task automatic test_wrap4();
    load(4, 32'hAAAA_0001); load(5, 32'hBBBB_0002); load(6, 32'hCCCC_0003); load(7, 32'hDDDD_0004);
    items.delete();
    rd(2'd2, 32'h18, 3'd2); rd(2'd3, 32'h1C, 3'd2); rd(2'd3, 32'h10, 3'd2); rd(2'd3, 32'h14, 3'd2);
    rd(2'd0, 32'h0, 3'd0);
    predict(); run_items();
    if (timed_out || obs.size() != exps.size()) begin
      checks++; failures++; $display("FAIL wrap4_count: got %0d transfers want %0d", obs.size(), exps.size());
    end else foreach (exps[k]) begin
      checks++;
      if (obs[k].waits !== exps[k].waits || obs[k].resp0 !== exps[k].err || obs[k].resp !== exps[k].err
          || (!exps[k].err && obs[k].data !== exps[k].data)) begin
        failures++;
        $display("FAIL wrap4 beat %0d: got waits=%0d resp=%b/%b data=%h want waits=%0d resp=%b data=%h",
                 k, obs[k].waits, obs[k].resp0, obs[k].resp, obs[k].data, exps[k].waits, exps[k].err, exps[k].data);
      end
    end
  endtask

  task automatic test_incr8_busy();
    items.delete();
    for (int j = 0; j < 8; j++) begin
      rd(j == 0 ? 2'd2 : 2'd3, 32'h40 + 32'(4 * j), 3'd5);
      if (j == 2) rd(2'd1, 32'h4C, 3'd5);
    end
    rd(2'd0, 32'h0, 3'd0);
    predict(); run_items();
    if (timed_out || obs.size() != exps.size()) begin
      checks++; failures++; $display("FAIL incr8_count: got %0d transfers want %0d", obs.size(), exps.size());
    end else foreach (exps[k]) begin
      checks++;
      if (obs[k].waits !== exps[k].waits || obs[k].resp0 !== exps[k].err || obs[k].resp !== exps[k].err
          || (!exps[k].err && obs[k].data !== exps[k].data)) begin
        failures++;
        $display("FAIL incr8 beat %0d: got waits=%0d resp=%b/%b data=%h want waits=%0d resp=%b data=%h",
                 k, obs[k].waits, obs[k].resp0, obs[k].resp, obs[k].data, exps[k].waits, exps[k].err, exps[k].data);
      end
    end
  endtask

  task automatic test_errors();
    items.delete();
    push(1'b1, 2'd2, 32'h0, 3'd0, 1'b1, 3'b010);         // write
    rd(2'd0, 32'h0, 3'd0);
    rd(2'd2, 32'h1C, 3'd3); rd(2'd3, 32'h24, 3'd3);      // SEQ off the expected 0x20
    rd(2'd0, 32'h0, 3'd0);
    rd(2'd2, BASE + 32'(4 * DEPTH), 3'd0);               // just past the window
    rd(2'd0, 32'h0, 3'd0);
    push(1'b1, 2'd2, 32'h20, 3'd0, 1'b0, 3'b000);        // byte size
    rd(2'd2, 32'h22, 3'd0);                              // misaligned
    rd(2'd3, 32'h24, 3'd0);                              // SEQ after SINGLE
    rd(2'd2, 32'h30, 3'd3); rd(2'd3, 32'h34, 3'd3); rd(2'd3, 32'h38, 3'd3); rd(2'd3, 32'h3C, 3'd3);
    rd(2'd3, 32'h40, 3'd3);                              // fifth beat of INCR4
    rd(2'd0, 32'h0, 3'd0);
    predict(); run_items();
    if (timed_out || obs.size() != exps.size()) begin
      checks++; failures++; $display("FAIL errors_count: got %0d transfers want %0d", obs.size(), exps.size());
    end else foreach (exps[k]) begin
      checks++;
      if (obs[k].waits !== exps[k].waits || obs[k].resp0 !== exps[k].err || obs[k].resp !== exps[k].err
          || (!exps[k].err && obs[k].data !== exps[k].data)) begin
        failures++;
        $display("FAIL errors beat %0d: got waits=%0d resp=%b/%b data=%h want waits=%0d resp=%b data=%h",
                 k, obs[k].waits, obs[k].resp0, obs[k].resp, obs[k].data, exps[k].waits, exps[k].err, exps[k].data);
      end
    end
  endtask

  task automatic test_rst_midburst();
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h80; hburst = 3'd3; hwrite = 1'b0; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0;
    checks++; if (hready !== 1'b0) begin failures++; $display("FAIL rst_wait_entered: hready got %b want 0", hready); end
    #2; rst = 1'b1; #1;
    checks++; if (hready !== 1'b1) begin failures++; $display("FAIL rst_mid_hready: got %b want 1", hready); end
    checks++; if (hresp !== 1'b0) begin failures++; $display("FAIL rst_mid_hresp: got %b want 0", hresp); end
    checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL rst_mid_hrdata: got %h want 0", hrdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_active = 0; m_last = '0;
    items.delete();
    for (int j = 0; j < 4; j++) rd(j == 0 ? 2'd2 : 2'd3, 32'h80 + 32'(4 * j), 3'd3);
    rd(2'd0, 32'h0, 3'd0);
    predict(); run_items();
    if (timed_out || obs.size() != exps.size()) begin
      checks++; failures++; $display("FAIL rst_after_count: got %0d transfers want %0d", obs.size(), exps.size());
    end else foreach (exps[k]) begin
      checks++;
      if (obs[k].waits !== exps[k].waits || obs[k].resp0 !== exps[k].err || obs[k].resp !== exps[k].err
          || (!exps[k].err && obs[k].data !== exps[k].data)) begin
        failures++;
        $display("FAIL rst_after beat %0d: got waits=%0d resp=%b/%b data=%h want waits=%0d resp=%b data=%h",
                 k, obs[k].waits, obs[k].resp0, obs[k].resp, obs[k].data, exps[k].waits, exps[k].err, exps[k].data);
      end
    end
  endtask

  task automatic test_read_before_write();
    logic [31:0] x, y;
    int c;
    x = $urandom; y = ~x;
    load(30, x);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h78; hburst = 3'd0; hwrite = 1'b0; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0;
    c = 0;
    do begin @(negedge clk); c++; end while (hready !== 1'b1 && c < 10);
    checks++; if (hready !== 1'b1) begin failures++; $display("FAIL rbw_timeout: hready got %b want 1", hready); end
    ld_en = 1'b1; ld_idx = IDX_W'(30); ld_data = y;
    #1;
    checks++; if (hrdata !== x) begin failures++; $display("FAIL rbw_data: got %h want %h", hrdata, x); end
    @(posedge clk); #1;
    ld_en = 1'b0;
    mem_m[30] = y; m_last = x; m_active = 0;
    checks++; if (hrdata !== x) begin failures++; $display("FAIL rbw_hold: got %h want %h", hrdata, x); end
    items.delete();
    rd(2'd2, 32'h78, 3'd0);
    rd(2'd0, 32'h0, 3'd0);
    predict(); run_items();
    checks++;
    if (timed_out || obs.size() != 2 || obs[0].data !== y || obs[0].resp !== 1'b0) begin
      failures++;
      $display("FAIL rbw_reread: got %0d transfers data=%h want data=%h", obs.size(),
               obs.size() > 0 ? obs[0].data : 32'hx, y);
    end
  endtask

  task automatic test_random();
    logic [2:0]  bt;
    logic [31:0] a, pa;
    int          n, g;
    items.delete();
    for (int b = 0; b < 40; b++) begin
      bt = 3'($urandom_range(0, 7));
      n  = (bt == 3'd1) ? int'($urandom_range(1, 6)) : beats_of(bt);
      a  = BASE + (32'($urandom_range(0, DEPTH - 80)) << 2);
      for (int j = 0; j < n; j++) begin
        pa = a;
        if (j > 0 && $urandom_range(0, 15) == 0) pa = a ^ 32'h8;
        rd(j == 0 ? 2'd2 : 2'd3, pa, bt);
        a = next_of(a, bt);
        if (j < n - 1 && $urandom_range(0, 5) == 0) rd(2'd1, a, bt);
      end
      g = int'($urandom_range(0, 3));
      if (g == 0) rd(2'd0, 32'h0, 3'd0);
      else if (g == 1) push(1'b0, 2'd2, 32'($urandom_range(0, 255)) << 2, 3'd0, 1'b0, 3'b010);
      else if (g == 2) push(1'b1, 2'd2, 32'($urandom_range(0, 255)) << 2, 3'd0, 1'b0, 3'b001);
    end
    rd(2'd0, 32'h0, 3'd0);
    predict(); run_items();
    if (timed_out || obs.size() != exps.size()) begin
      checks++; failures++; $display("FAIL random_count: got %0d transfers want %0d", obs.size(), exps.size());
    end else foreach (exps[k]) begin
      checks++;
      if (obs[k].waits !== exps[k].waits || obs[k].resp0 !== exps[k].err || obs[k].resp !== exps[k].err
          || (!exps[k].err && obs[k].data !== exps[k].data)) begin
        failures++;
        $display("FAIL random beat %0d: got waits=%0d resp=%b/%b data=%h want waits=%0d resp=%b data=%h",
                 k, obs[k].waits, obs[k].resp0, obs[k].resp, obs[k].data, exps[k].waits, exps[k].err, exps[k].data);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap4();
    test_incr8_busy();
    test_errors();
    test_rst_midburst();
    test_read_before_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
